// File: rtl/ram_mapper.sv
// MSX memory mapper: four I/O page registers (0xFC-0xFF) map CPU pages onto a large byte-wide SRAM,
// with timed SRAM strobes and nwait stretching. Optional I/O readback of page registers via MAPPER_READBACK_EN.
module ram_mapper #(
  parameter int PAGE_BITS   = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      nsltsel,
  input  logic                      nmreq,
  input  logic                      niorq,
  input  logic                      nrd,
  input  logic                      nwr,
  input  logic [15:0]               addr,
  input  logic [7:0]                cpu_din,
  output logic [7:0]                cpu_dout,
  output logic                      cpu_doe,
  output logic                      nwait,
  output logic [14+PAGE_BITS-1:0]   sram_addr,
  input  logic [7:0]                sram_din,
  output logic [7:0]                sram_dout,
  output logic                      sram_nce,
  output logic                      sram_noe,
  output logic                      sram_nwe
);
  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  state_t state, state_nxt;

  logic [2:0]           cnt;
  logic                 is_rd;
  logic                 mem_rd, mem_wr, mem_rd_q, mem_wr_q;
  logic                 rd_start, wr_start, active;
  logic                 io_wr, io_wr_q;
  logic [PAGE_BITS-1:0] page [4];
  logic                 doe_q;
  logic [7:0]           dout_q;

  assign mem_rd   = !nsltsel && !nmreq && !nrd;
  assign mem_wr   = !nsltsel && !nmreq && !nwr;
  assign rd_start = mem_rd && !mem_rd_q;
  assign wr_start = mem_wr && !mem_wr_q;
  assign active   = is_rd ? mem_rd : mem_wr;
  assign io_wr    = !niorq && !nwr && (addr[7:2] == 6'b111111);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A released read strobe aborts at once; a write always runs its full length.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_start || wr_start) state_nxt = ACCESS;
      ACCESS: begin
        if (is_rd && !mem_rd)  state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = active ? HOLD : IDLE;
      end
      HOLD:    if (!active) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 3'd0;
      is_rd     <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      io_wr_q   <= 1'b0;
      for (int i = 0; i < 4; i++) page[i] <= PAGE_BITS'(3 - i);
      sram_addr <= '0;
      sram_dout <= 8'h00;
      sram_nce  <= 1'b1;
      sram_noe  <= 1'b1;
      sram_nwe  <= 1'b1;
      nwait     <= 1'b1;
      doe_q     <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      mem_rd_q <= mem_rd;
      mem_wr_q <= mem_wr;
      io_wr_q  <= io_wr;
      if (io_wr && !io_wr_q) page[addr[1:0]] <= cpu_din[PAGE_BITS-1:0];

      case (state)
        IDLE: begin
          if (state_nxt == ACCESS) begin
            is_rd     <= rd_start;
            cnt       <= 3'd0;
            sram_addr <= {page[addr[15:14]], addr[13:0]};
            if (!rd_start) sram_dout <= cpu_din;
            sram_nce  <= 1'b0;
            sram_noe  <= !rd_start;
            sram_nwe  <= rd_start;
            nwait     <= (WAIT_CYCLES == 0);
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (state_nxt != ACCESS) begin
            sram_nce <= 1'b1;
            sram_noe <= 1'b1;
            sram_nwe <= 1'b1;
            nwait    <= 1'b1;
            if (is_rd && state_nxt == HOLD) begin
              dout_q <= sram_din;
              doe_q  <= 1'b1;
            end
          end else if (cnt + 3'd1 == LAST) begin
            // nwait covers only the stretch; the final strobe cycle runs unstalled.
            nwait <= 1'b1;
          end
        end
        HOLD: begin
          if (state_nxt == IDLE) doe_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MAPPER_READBACK_EN
  logic       io_rd;
  logic [7:0] rb;

  assign io_rd = !niorq && !nrd && (addr[7:2] == 6'b111111);

  always_comb begin
    rb                  = 8'hFF;
    rb[PAGE_BITS-1:0]   = page[addr[1:0]];
  end

  assign cpu_dout = io_rd ? rb : dout_q;
  assign cpu_doe  = io_rd || doe_q;
`else
  assign cpu_dout = dout_q;
  assign cpu_doe  = doe_q;
`endif

endmodule

// File: tb/tb_ram_mapper.sv
// Self-checking bench for ram_mapper: directed steps plus random I/O and memory traffic against a
// page-table/memory reference model. Readback checks depend on MAPPER_READBACK_EN.
module tb_ram_mapper;
  localparam int PAGE_BITS   = 4;
  localparam int WAIT_CYCLES = 1;
  localparam int AW          = 14 + PAGE_BITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          nsltsel, nmreq, niorq, nrd, nwr;
  logic [15:0]   addr;
  logic [7:0]    cpu_din, cpu_dout, sram_din, sram_dout;
  logic          cpu_doe, nwait, sram_nce, sram_noe, sram_nwe;
  logic [AW-1:0] sram_addr;

  always #5 clk = ~clk;

  ram_mapper #(.PAGE_BITS(PAGE_BITS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .nsltsel(nsltsel), .nmreq(nmreq), .niorq(niorq),
    .nrd(nrd), .nwr(nwr), .addr(addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_doe(cpu_doe), .nwait(nwait), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout), .sram_nce(sram_nce), .sram_noe(sram_noe), .sram_nwe(sram_nwe)
  );

  // SRAM device attached to the DUT
  logic [7:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) if (!sram_nce && !sram_nwe) sram_mem[sram_addr] <= sram_dout;
  assign sram_din = (!sram_nce && !sram_noe) ? sram_mem[sram_addr] : 8'h00;

  // Reference model: page table and byte memory keyed by physical address
  int         ref_page [4];
  logic [7:0] ref_mem [int];
  logic [7:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;

  function automatic int xlate(input logic [15:0] a);
    return (ref_page[a[15:14]] << 14) + int'(a[13:0]);
  endfunction

  function automatic logic [7:0] ref_rd(input int pa);
    return ref_mem.exists(pa) ? ref_mem[pa] : 8'h00;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 4; i++) ref_page[i] = 3 - i;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    nsltsel = 1'b1; nmreq = 1'b1; niorq = 1'b1; nrd = 1'b1; nwr = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full memory cycle; the strobe is held `hold` extra cycles after the SRAM access ends.
  task automatic mem_cycle(input bit wr, input logic [15:0] a, input logic [7:0] d, input int hold);
    int pa, strb, nwl, wrong, doe_early, extra, lost;
    bit seen, act_low;
    logic [AW-1:0] seen_addr;
    logic [7:0]    seen_dout;
    pa = xlate(a);
    strb = 0; nwl = 0; wrong = 0; doe_early = 0; extra = 0; lost = 0; seen = 0;
    seen_addr = '0; seen_dout = 8'h00;
    addr = a; cpu_din = d; nsltsel = 1'b0; nmreq = 1'b0;
    if (wr) nwr = 1'b0; else nrd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      act_low = !sram_nce && (wr ? !sram_nwe : !sram_noe);
      if (seen && !act_low) break;
      if (act_low) begin
        if (!seen) begin seen_addr = sram_addr; seen_dout = sram_dout; end
        seen = 1'b1;
        strb++;
        if (!nwait) nwl++;
        if (cpu_doe) doe_early++;
        if (wr ? !sram_noe : !sram_nwe) wrong++;
      end
    end
    check(wr ? "wr_strobe_len" : "rd_strobe_len", strb, WAIT_CYCLES + 1);
    check("nwait_len", nwl, WAIT_CYCLES);
    check("sram_addr", seen_addr, pa);
    check("wrong_strobe", wrong, 0);
    check("doe_during_access", doe_early, 0);
    if (wr) begin
      check("sram_dout", seen_dout, d);
      ref_mem[pa] = d;
    end else begin
      exp_q.push_back(ref_rd(pa));
      check("rd_doe", cpu_doe, 1'b1);
      check("rd_data", cpu_dout, exp_q.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!sram_nce) extra++;
      if (!wr && !cpu_doe) lost++;
    end
    check("held_strobe_restart", extra, 0);
    check("held_doe", lost, 0);
    bus_idle();
    tick();
    check("doe_after_release", cpu_doe, 1'b0);
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    addr = {8'($urandom), port}; cpu_din = d; niorq = 1'b0; nwr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_idle();
    tick();
    if (port[7:2] == 6'b111111) ref_page[port[1:0]] = d % (1 << PAGE_BITS);
  endtask

  task automatic io_read(input logic [7:0] port);
    logic [7:0] exp;
    exp = 8'((32'hFF << PAGE_BITS) | ref_page[port[1:0]]);
    addr = {8'($urandom), port}; niorq = 1'b0; nrd = 1'b0;
    #2;
`ifdef MAPPER_READBACK_EN
    check("io_rd_doe", cpu_doe, 1'b1);
    check("io_rd_data", cpu_dout, exp);
    tick();
    check("io_rd_data_held", cpu_dout, exp);
`else
    check("io_rd_doe_off", cpu_doe, 1'b0);
    tick();
    check("io_rd_doe_off_held", cpu_doe, 1'b0);
`endif
    bus_idle();
    tick();
    check("io_rd_release", cpu_doe, 1'b0);
  endtask

  initial begin : main
    int cnt_a, cnt_b, cnt_c, pa;
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 8'h00;
    ref_reset();
    bus_idle();
    addr = 16'h0000; cpu_din = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nce", sram_nce, 1'b1);
    check("rst_noe", sram_noe, 1'b1);
    check("rst_nwe", sram_nwe, 1'b1);
    check("rst_nwait", nwait, 1'b1);
    check("rst_doe", cpu_doe, 1'b0);
    check("rst_dout", cpu_dout, 8'h00);
    check("rst_addr", sram_addr, 0);
    check("rst_sram_dout", sram_dout, 8'h00);
    reset = 1'b0;
    tick();

    // Basic write/read through reset mapping
    mem_cycle(1'b1, 16'h1234, 8'h42, 0);
    check("xlate_0x1234", xlate(16'h1234), 32'h0D234);
    mem_cycle(1'b0, 16'h1234, 8'h00, 3);

    // Remap page 3
    io_write(8'hFF, 8'h05);
    mem_cycle(1'b1, 16'hF234, 8'h24, 0);
    check("xlate_0xF234", xlate(16'hF234), 32'h17234);
    mem_cycle(1'b0, 16'hF234, 8'h00, 1);
    mem_cycle(1'b0, 16'h3234, 8'h00, 0);

    // Aliasing through a shared segment
    io_write(8'hFC, 8'h07);
    io_write(8'hFD, 8'h07);
    mem_cycle(1'b1, 16'h0010, 8'h5A, 0);
    mem_cycle(1'b0, 16'h4010, 8'h00, 0);

    // Upper data bits ignored, plus readback
    io_write(8'hFE, 8'h25);
    check("page_fe_masked", ref_page[2], 5);
    io_read(8'hFE);
`ifdef MAPPER_READBACK_EN
    addr = 16'h00FE; niorq = 1'b0; nrd = 1'b0;
    #2;
    check("io_rd_fe_literal", cpu_dout, 8'hF5);
    bus_idle();
    tick();
`endif
    mem_cycle(1'b1, 16'h8001, 8'hC3, 0);
    mem_cycle(1'b0, 16'h8001, 8'h00, 0);

    // Port outside the mapper range must not change any page
    io_write(8'hFB, 8'h0E);
    mem_cycle(1'b0, 16'h8001, 8'h00, 0);

    // Slot not selected: no access at all
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    addr = 16'h1234; nsltsel = 1'b1; nmreq = 1'b0; nrd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!sram_nce || !sram_noe || !sram_nwe) cnt_a++;
      if (!nwait) cnt_b++;
      if (cpu_doe) cnt_c++;
    end
    check("nslt_strobe", cnt_a, 0);
    check("nslt_nwait", cnt_b, 0);
    check("nslt_doe", cnt_c, 0);
    bus_idle();
    tick();

    // Read abort: strobe released during ACCESS
    addr = 16'h1234; nsltsel = 1'b0; nmreq = 1'b0; nrd = 1'b0;
    tick();
    check("abort_rd_started", sram_noe, 1'b0);
    bus_idle();
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!sram_nce || !sram_noe) cnt_a++;
      if (!nwait) cnt_b++;
      if (cpu_doe) cnt_c++;
    end
    check("abort_rd_strobe", cnt_a, 0);
    check("abort_rd_nwait", cnt_b, 0);
    check("abort_rd_doe", cnt_c, 0);

    // Write abort: write still runs its full length
    a = 16'h4321; d = 8'h99;
    pa = xlate(a);
    addr = a; cpu_din = d; nsltsel = 1'b0; nmreq = 1'b0; nwr = 1'b0;
    tick();
    cnt_a = (!sram_nwe) ? 1 : 0;
    check("abort_wr_addr", sram_addr, pa);
    bus_idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!sram_nwe) cnt_a++;
    end
    check("abort_wr_len", cnt_a, WAIT_CYCLES + 1);
    ref_mem[pa] = d;
    mem_cycle(1'b0, a, 8'h00, 0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      a = {2'($urandom), 14'($urandom_range(0, 15))};
      d = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1: io_write(($urandom_range(0, 4) == 0) ? 8'hFB : 8'(8'hFC + $urandom_range(0, 3)), d);
        2, 3, 4, 5: mem_cycle(1'b1, a, d, 0);
        default: mem_cycle(1'b0, a, d, $urandom_range(0, 2));
      endcase
    end

    // Reset in the second ACCESS cycle of a write
    io_write(8'hFC, 8'h0B);
    a = 16'h0123; d = 8'h6D;
    pa = xlate(a);
    addr = a; cpu_din = d; nsltsel = 1'b0; nmreq = 1'b0; nwr = 1'b0;
    repeat (2) tick();
    check("rst_mid_wr_active", sram_nwe, 1'b0);
    reset = 1'b1;
    bus_idle();
    tick();
    check("rst_mid_nce", sram_nce, 1'b1);
    check("rst_mid_nwe", sram_nwe, 1'b1);
    check("rst_mid_nwait", nwait, 1'b1);
    reset = 1'b0;
    ref_mem[pa] = d;
    ref_reset();
    tick();
    for (int p = 0; p < 4; p++) begin
      a = 16'((p << 14) | $urandom_range(0, 15));
      mem_cycle(1'b1, a, 8'(8'hA0 + p), 0);
      mem_cycle(1'b0, a, 8'h00, 0);
    end
    io_read(8'hFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
